cfa_patch_window_5x5: RTL

- Converts a raster-order 12-bit Bayer pixel stream into the 5x5 patch bus p_m2_m2..p_p2_p2 plus the start strobe consumed by gradients_2.
- Sits between the sensor/frame reader and the gradient stage. Contains 4 line buffers and a 5x5 register window.
- Emits one patch per accepted pixel once the window lies fully inside the image.
- Border pixels produce no patch; no padding is applied.

---
 rtl/cfa_pkg.sv | 20 ++
 rtl/cfa_line_buffer.sv | 30 +++
 rtl/cfa_patch_window_5x5.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cfa_pkg.sv
// Shared constants for the CFA patch window and its gradient-stage consumer.
// The tap index convention (m2..p2) is common to both stages: index 0 is the
// oldest row / leftmost column, index 4 the newest row / rightmost column.
package cfa_pkg;

    localparam int PIX_W     = 12;
    localparam int PATCH_N   = 5;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    // Row or column offset of a tap relative to the patch centre.
    typedef enum logic [2:0] {
        TAP_M2 = 3'd0,
        TAP_M1 = 3'd1,
        TAP_P0 = 3'd2,
        TAP_P1 = 3'd3,
        TAP_P2 = 3'd4
    } tap_e;

endpackage

// File: rtl/cfa_line_buffer.sv
// One line of pixel history: single-port RAM, read-before-write.
// The read is combinational, so dout shows the value stored before this
// cycle's write, which lets the buffers be chained in the same cycle.
module cfa_line_buffer
    import cfa_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int W     = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem_q [DEPTH];

    assign dout = mem_q[addr];

    // Store the incoming pixel; the old value has already left through dout.
    // NOTE: RAM contents carry no reset; a reset port would force the array into flops.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/cfa_patch_window_5x5.sv
// Raster Bayer stream to 5x5 patch bus. Four chained line buffers feed a
// 5x5 register window; start flags a patch whose window lies fully inside
// the image of a frame that began with sof.
module cfa_patch_window_5x5 #(
    parameter int IMG_W = cfa_pkg::DEF_IMG_W,
    parameter int IMG_H = cfa_pkg::DEF_IMG_H,
    parameter int PIX_W = cfa_pkg::PIX_W,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
    output logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
    output logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
    output logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
    output logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
    output logic             start,
    output logic [RW-1:0]    cen_row,
    output logic [CW-1:0]    cen_col,
    output logic             frame_done
);

    import cfa_pkg::*;

    localparam int          LB_N     = PATCH_N - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(PATCH_N - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(PATCH_N - 1);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic             armed_q, armed_d;
    logic             start_q, start_d;
    logic             frame_done_q, frame_done_d;
    logic [RW-1:0]    cen_row_q, cen_row_d;
    logic [CW-1:0]    cen_col_q, cen_col_d;
    logic [PIX_W-1:0] win_q [PATCH_N][PATCH_N];
    logic [PIX_W-1:0] win_d [PATCH_N][PATCH_N];
    logic [PIX_W-1:0] lb_din  [LB_N];
    logic [PIX_W-1:0] lb_dout [LB_N];

    // sof restarts the raster position before the pixel presented with it is used.
    assign cur_col = sof ? '0 : col_q;
    assign cur_row = sof ? '0 : row_q;

    // Line buffer k holds row r-1-k; each accepted pixel ripples one row down the chain.
    assign lb_din[0] = pix_in;
    for (genvar i = 1; i < LB_N; i++) begin : g_chain
        assign lb_din[i] = lb_dout[i-1];
    end

    for (genvar i = 0; i < LB_N; i++) begin : g_lb
        cfa_line_buffer #(
            .DEPTH (IMG_W),
            .W     (PIX_W),
            .AW    (CW)
        ) u_lb (
            .clk  (clk),
            .en   (pix_valid),
            .addr (cur_col),
            .din  (lb_din[i]),
            .dout (lb_dout[i])
        );
    end

    // Next-state: raster counters, window shift and start/frame_done strobes.
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        armed_d      = armed_q;
        cen_row_d    = cen_row_q;
        cen_col_d    = cen_col_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        win_d        = win_q;

        if (pix_valid) begin
            if (sof) begin
                armed_d = 1'b1;
            end

            start_d      = armed_d && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
            frame_done_d = armed_d && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

            if (start_d) begin
                cen_row_d = cur_row - RW'(2);
                cen_col_d = cur_col - CW'(2);
            end

            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end

            for (int r = 0; r < PATCH_N; r++) begin
                for (int k = 0; k < PATCH_N - 1; k++) begin
                    win_d[r][k] = win_q[r][k+1];
                end
            end
            // Oldest row comes from the last buffer in the chain.
            for (int r = 0; r < LB_N; r++) begin
                win_d[r][PATCH_N-1] = lb_dout[LB_N-1-r];
            end
            win_d[PATCH_N-1][PATCH_N-1] = pix_in;
        end
    end

    // State registers; reset clears counters, window and all strobes.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            armed_q      <= 1'b0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cen_row_q    <= '0;
            cen_col_q    <= '0;
            for (int r = 0; r < PATCH_N; r++) begin
                for (int k = 0; k < PATCH_N; k++) begin
                    win_q[r][k] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            armed_q      <= armed_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
            cen_row_q    <= cen_row_d;
            cen_col_q    <= cen_col_d;
            win_q        <= win_d;
        end
    end

    assign start      = start_q;
    assign frame_done = frame_done_q;
    assign cen_row    = cen_row_q;
    assign cen_col    = cen_col_q;

    assign p_m2_m2 = win_q[TAP_M2][TAP_M2];
    assign p_m2_m1 = win_q[TAP_M2][TAP_M1];
    assign p_m2_p0 = win_q[TAP_M2][TAP_P0];
    assign p_m2_p1 = win_q[TAP_M2][TAP_P1];
    assign p_m2_p2 = win_q[TAP_M2][TAP_P2];
    assign p_m1_m2 = win_q[TAP_M1][TAP_M2];
    assign p_m1_m1 = win_q[TAP_M1][TAP_M1];
    assign p_m1_p0 = win_q[TAP_M1][TAP_P0];
    assign p_m1_p1 = win_q[TAP_M1][TAP_P1];
    assign p_m1_p2 = win_q[TAP_M1][TAP_P2];
    assign p_p0_m2 = win_q[TAP_P0][TAP_M2];
    assign p_p0_m1 = win_q[TAP_P0][TAP_M1];
    assign p_p0_p0 = win_q[TAP_P0][TAP_P0];
    assign p_p0_p1 = win_q[TAP_P0][TAP_P1];
    assign p_p0_p2 = win_q[TAP_P0][TAP_P2];
    assign p_p1_m2 = win_q[TAP_P1][TAP_M2];
    assign p_p1_m1 = win_q[TAP_P1][TAP_M1];
    assign p_p1_p0 = win_q[TAP_P1][TAP_P0];
    assign p_p1_p1 = win_q[TAP_P1][TAP_P1];
    assign p_p1_p2 = win_q[TAP_P1][TAP_P2];
    assign p_p2_m2 = win_q[TAP_P2][TAP_M2];
    assign p_p2_m1 = win_q[TAP_P2][TAP_M1];
    assign p_p2_p0 = win_q[TAP_P2][TAP_P0];
    assign p_p2_p1 = win_q[TAP_P2][TAP_P1];
    assign p_p2_p2 = win_q[TAP_P2][TAP_P2];

endmodule
